usb_tx_encoder: RTL and testbench
=================================

Name: usb_tx_encoder

Overview:
USB transmit path: the transmit-side counterpart of the receive shift register, sitting between the packet/protocol layer and the D+/D- line drivers. Accepts packet bytes over a valid/ready handshake and prepends SYNC. Serializes each byte LSB-first, applies bit stuffing and NRZI encoding, then terminates every packet with EOP. One bit period spans CLKS_PER_BIT clocks.

Parameters:
CLKS_PER_BIT, 8, clocks per USB bit period; legal range is 2 or more.

Ports:
clk  input  1  system clock; all state changes on its rising edge
n_rst  input  1  asynchronous reset, active-low
tx_data  input  8  packet byte, sent LSB first
tx_valid  input  1  tx_data and tx_last are valid
tx_last  input  1  the current byte is the final byte of the packet
tx_ready  output  1  holding register is empty; a byte is accepted when tx_valid && tx_ready
d_plus  output  1  encoded D+ line
d_minus  output  1  encoded D- line
tx_busy  output  1  a packet is in progress (from the SYNC bit through the end of EOP)
tx_done  output  1  one-cycle pulse when EOP completes
tx_err  output  1  one-cycle pulse when an underrun is detected

Behaviour:
- Reset:
  - State IDLE; d_plus=1, d_minus=0 (J).
  - tx_ready=1, tx_busy=0, tx_done=0, tx_err=0.
  - Holding register empty; stuff counter 0; bit timer 0.
- Datapath structure:
  - One 8-bit holding register plus one 8-bit shift register.
  - tx_ready = holding register empty.
  - The accepted tx_last is stored with its byte.
- Bit timer:
  - Counts 0..CLKS_PER_BIT-1 while not in IDLE.
  - A bit boundary occurs at count==CLKS_PER_BIT-1.
  - Line outputs are registered and change only on bit boundaries, or on the IDLE->SYNC entry.
- States and transitions:
  - IDLE: on accept, go to SYNC. The byte goes to the holding register and the timer clears. The first SYNC bit appears on the line the cycle after the accept.
  - SYNC: sends raw bits 0,0,0,0,0,0,0,1. At the final boundary, the holding register moves into the shifter and the state goes to DATA. If the holding register is empty at that point, this is an underrun.
  - DATA: shifts one bit per boundary. After bit 7 of a byte:
    - if the byte was last, go to EOP_SE0;
    - else if the holding register is full, load the shifter and continue with no gap;
    - else underrun.
  - EOP_SE0: drive d_plus=0, d_minus=0 for 2 bit periods, then go to EOP_J.
  - EOP_J: drive J for 1 bit period. Then pulse tx_done, go to IDLE, deassert tx_busy, clear the stuff counter.
- Underrun:
  - Pulse tx_err for one cycle, discard the remaining packet, go directly to EOP_SE0. tx_done still pulses at the end of EOP.
- Bit stuffing:
  - Applies to raw bits from SYNC through the last data bit.
  - The counter increments on each raw 1 and clears on each 0.
  - When the count reaches 6, the next bit period transmits a stuffed 0: the shifter stalls for that period and the counter clears.
  - The last SYNC bit leaves the count at 1.
  - A stuff owed after the last data bit is still sent before EOP.
- NRZI:
  - A 0 (raw or stuffed) toggles the line between J (1,0) and K (0,1); a 1 holds the current level.
  - Encoding starts from J. SYNC therefore appears as K J K J K J K K.
- Handshake:
  - Bytes can be accepted in any state before EOP, whenever the holding register is empty.
  - tx_ready is held low during EOP_SE0 and EOP_J; it returns to 1 in IDLE.
  - Accepts after a tx_last byte has been accepted are blocked until IDLE.
- Simultaneous events: a holding-register load and a shifter transfer in the same cycle are legal, and the holding register ends up full.
- Reset mid-packet: the asynchronous reset immediately returns all outputs to their reset values, with the line at J.

Test Plan:
- Reset, then idle for 20 cycles with tx_valid=0 -> d_plus=1, d_minus=0, tx_ready=1, tx_busy=0, no pulses.
- Single byte 0x00 with tx_last=1 (CLKS_PER_BIT=8):
  - line shows SYNC K J K J K J K K, then J K J K J K J K, then 16 cycles SE0, then 8 cycles J;
  - tx_done pulses exactly 152 cycles after the accept.
- Single byte 0xFF with tx_last=1:
  - after SYNC, 5 bit periods K, then stuffed J, then 3 periods J, then EOP;
  - data phase lasts 9 bit periods.
- Three back-to-back bytes 0xA5, 0x3C, 0x81 (last) presented whenever tx_ready=1 -> contiguous bitstream with no idle gap, decoded by the RX model as A5 3C 81; exactly one tx_done.
- Underrun: send 0x12 with tx_last=0 and withhold the next byte -> tx_err pulses once after bit 7, SE0 follows, then tx_done.
- Assert n_rst low during the 3rd data bit -> outputs return to J / ready=1 / busy=0 in the same cycle; a following packet transmits correctly.

Source files
------------

// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder: USB transmit serializer.
// Takes packet bytes over a valid/ready handshake, prepends SYNC, shifts
// each byte out LSB first with bit stuffing and NRZI encoding, and closes
// every packet with EOP (two bit periods of SE0, then one of J).
// Ports:
//   clk, n_rst          clock, asynchronous active-low reset
//   tx_data/valid/last  byte input; accepted when tx_valid && tx_ready
//   tx_ready            holding register can take a byte
//   d_plus, d_minus     registered line outputs (J = 1,0  K = 0,1)
//   tx_busy             packet in progress, SYNC through end of EOP
//   tx_done             one-cycle pulse when EOP completes
//   tx_err              one-cycle pulse on underrun
module usb_tx_encoder #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_END = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP_SE0, S_EOP_J} state_t;

  state_t          r_state, w_state_n;
  logic [TW-1:0]   r_timer;
  logic [2:0]      r_bitcnt;
  logic [7:0]      r_hold, r_shift;
  logic            r_hold_full, r_hold_last, r_shift_last;
  logic            r_last_acc;     // tx_last byte accepted; block further accepts
  logic [2:0]      r_stuff;
  logic            r_lvl;          // NRZI level, 1 = J
  logic            r_dp, r_dm, r_done, r_err;

  logic            w_bnd, w_ready, w_accept;
  logic [2:0]      w_bit_nxt;
  logic            w_emit_raw, w_raw_bit, w_emit_stuff;
  logic            w_xfer, w_err, w_done, w_se0, w_j, w_bit_inc, w_bit_clr;
  logic            w_lvl_n;

  assign w_bnd     = (r_state != S_IDLE) && (r_timer == BIT_END);
  assign w_ready   = !r_hold_full && !r_last_acc &&
                     (r_state == S_IDLE || r_state == S_SYNC || r_state == S_DATA);
  assign w_accept  = tx_valid && w_ready;
  assign w_bit_nxt = r_bitcnt + 3'd1;
  // a zero, raw or stuffed, toggles the line; a one holds it
  assign w_lvl_n   = (w_emit_stuff || (w_emit_raw && !w_raw_bit)) ? ~r_lvl : r_lvl;

  always_comb begin
    w_state_n    = r_state;
    w_emit_raw   = 1'b0;
    w_raw_bit    = 1'b0;
    w_emit_stuff = 1'b0;
    w_xfer       = 1'b0;
    w_err        = 1'b0;
    w_done       = 1'b0;
    w_se0        = 1'b0;
    w_j          = 1'b0;
    w_bit_inc    = 1'b0;
    w_bit_clr    = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) begin
        // first SYNC bit (a zero) goes on the line right away
        w_state_n  = S_SYNC;
        w_emit_raw = 1'b1;
        w_bit_clr  = 1'b1;
      end
      S_SYNC: if (w_bnd) begin
        if (r_bitcnt != 3'd7) begin
          w_bit_inc  = 1'b1;
          w_emit_raw = 1'b1;
          w_raw_bit  = (r_bitcnt == 3'd6);
        end else if (r_hold_full) begin
          w_state_n  = S_DATA;
          w_xfer     = 1'b1;
          w_bit_clr  = 1'b1;
          w_emit_raw = 1'b1;
          w_raw_bit  = r_hold[0];
        end else begin
          w_state_n = S_EOP_SE0;
          w_err     = 1'b1;
          w_se0     = 1'b1;
          w_bit_clr = 1'b1;
        end
      end
      S_DATA: if (w_bnd) begin
        // an owed stuff bit goes first, even after bit 7; the shifter holds
        if (r_stuff == 3'd6) begin
          w_emit_stuff = 1'b1;
        end else if (r_bitcnt != 3'd7) begin
          w_bit_inc  = 1'b1;
          w_emit_raw = 1'b1;
          w_raw_bit  = r_shift[w_bit_nxt];
        end else if (r_shift_last) begin
          w_state_n = S_EOP_SE0;
          w_se0     = 1'b1;
          w_bit_clr = 1'b1;
        end else if (r_hold_full) begin
          w_xfer     = 1'b1;
          w_bit_clr  = 1'b1;
          w_emit_raw = 1'b1;
          w_raw_bit  = r_hold[0];
        end else begin
          w_state_n = S_EOP_SE0;
          w_err     = 1'b1;
          w_se0     = 1'b1;
          w_bit_clr = 1'b1;
        end
      end
      S_EOP_SE0: if (w_bnd) begin
        if (r_bitcnt == 3'd1) begin
          w_state_n = S_EOP_J;
          w_j       = 1'b1;
          w_bit_clr = 1'b1;
        end else begin
          w_bit_inc = 1'b1;
        end
      end
      S_EOP_J: if (w_bnd) begin
        w_state_n = S_IDLE;
        w_done    = 1'b1;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_bitcnt     <= '0;
      r_hold       <= '0;
      r_hold_full  <= 1'b0;
      r_hold_last  <= 1'b0;
      r_shift      <= '0;
      r_shift_last <= 1'b0;
      r_last_acc   <= 1'b0;
      r_stuff      <= '0;
      r_lvl        <= 1'b1;
      r_dp         <= 1'b1;
      r_dm         <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_done  <= w_done;
      r_err   <= w_err;

      if (r_state == S_IDLE || w_bnd) r_timer <= '0;
      else                            r_timer <= r_timer + 1'b1;

      if (w_bit_clr)      r_bitcnt <= '0;
      else if (w_bit_inc) r_bitcnt <= w_bit_nxt;

      // load wins over the drain so a same-cycle load leaves the register full
      if (w_accept) begin
        r_hold      <= tx_data;
        r_hold_last <= tx_last;
        r_hold_full <= 1'b1;
      end else if (w_xfer || w_err) begin
        r_hold_full <= 1'b0;
      end

      if (w_done)                   r_last_acc <= 1'b0;
      else if (w_accept && tx_last) r_last_acc <= 1'b1;

      if (w_xfer) begin
        r_shift      <= r_hold;
        r_shift_last <= r_hold_last;
      end

      if (w_done || w_emit_stuff) r_stuff <= '0;
      else if (w_emit_raw)        r_stuff <= w_raw_bit ? r_stuff + 3'd1 : 3'd0;

      if (w_emit_raw || w_emit_stuff) begin
        r_lvl <= w_lvl_n;
        r_dp  <= w_lvl_n;
        r_dm  <= ~w_lvl_n;
      end else if (w_se0) begin
        r_dp <= 1'b0;
        r_dm <= 1'b0;
      end else if (w_j) begin
        r_lvl <= 1'b1;
        r_dp  <= 1'b1;
        r_dm  <= 1'b0;
      end
    end
  end

  assign tx_ready = w_ready;
  assign tx_busy  = (r_state != S_IDLE);
  assign d_plus   = r_dp;
  assign d_minus  = r_dm;
  assign tx_done  = r_done;
  assign tx_err   = r_err;
endmodule

// File: tb/tb_usb_tx_encoder.sv
// Directed bench for usb_tx_encoder: accepted bytes go into a scoreboard
// queue; a line monitor samples each bit period mid-way and an RX model
// (NRZI decode, destuff, SYNC/EOP checks) pops and compares the bytes.
`timescale 1ns/1ps
module tb_usb_tx_encoder;
  localparam int CPB = 8;
  localparam int P   = 10;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_ready, d_plus, d_minus, tx_busy, tx_done, tx_err;

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic [1:0] sym_q[$];
  int         phase = 0;

  always #(P/2) clk = ~clk;

  usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .n_rst(n_rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_last(tx_last), .tx_ready(tx_ready), .d_plus(d_plus),
    .d_minus(d_minus), .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err)
  );

  // one line sample per bit period, mid-period, while a packet is in flight
  always @(negedge clk) begin
    if (!n_rst || !tx_busy) phase <= 0;
    else begin
      if (phase == CPB/2) sym_q.push_back({d_plus, d_minus});
      phase <= (phase == CPB-1) ? 0 : phase + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // called at a negedge; returns at the negedge after the accepting posedge
  task automatic send_byte(input logic [7:0] d, input logic last, output time t_acc);
    bit ok;
    ok = 1'b0;
    t_acc = 0;
    tx_data = d; tx_last = last; tx_valid = 1'b1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      if (tx_ready === 1'b1) begin
        @(posedge clk);
        t_acc = $time;
        exp_q.push_back(d);
        ok = 1'b1;
        #1 tx_valid = 1'b0;
      end
      @(negedge clk);
    end
    tx_valid = 1'b0;
    chk("accept_timeout", {31'd0, ok}, 32'd1);
  endtask

  // cycles from accept edge to each pulse; pulses counted until 10 cycles past done
  task automatic wait_done(input time t0, output int dd, output int de, output int nd, output int ne);
    int extra;
    dd = -1; de = -1; nd = 0; ne = 0; extra = -1;
    for (int i = 0; i < 600 && extra != 0; i++) begin
      @(negedge clk);
      if (tx_err === 1'b1) begin ne++; if (de < 0) de = int'(($time - t0 - P/2) / P); end
      if (tx_done === 1'b1) begin nd++; if (dd < 0) dd = int'(($time - t0 - P/2) / P); end
      if (extra > 0) extra--;
      else if (extra < 0 && nd > 0) extra = 10;
    end
  endtask

  // K = 0,1  J = 1,0  '0' = SE0
  task automatic chk_syms(input string tag, input string s);
    int nbad;
    logic [1:0] e;
    nbad = 0;
    for (int i = 0; i < s.len(); i++) begin
      e = (s[i] == "K") ? 2'b01 : (s[i] == "J") ? 2'b10 : 2'b00;
      if (i >= sym_q.size() || sym_q[i] !== e) nbad++;
    end
    chk({tag, "_len"}, sym_q.size(), s.len());
    chk({tag, "_syms"}, nbad, 0);
  endtask

  task automatic check_pkt(input string tag);
    logic [1:0] prev;
    logic [7:0] sh, e;
    logic       b;
    int ones, nb, i, nse0, nj, sbad;
    prev = 2'b10; sh = 8'h00; ones = 0; nb = 0; i = 0; sbad = 0;
    while (i < sym_q.size() && sym_q[i] !== 2'b00) begin
      b = (sym_q[i] === prev);
      prev = sym_q[i];
      i++;
      if (ones == 6) begin
        if (b) sbad++;
        ones = 0;
      end else begin
        sh = {b, sh[7:1]};
        nb++;
        ones = b ? ones + 1 : 0;
        if (nb == 8) chk({tag, "_sync"}, {24'd0, sh}, 32'h80);
        else if (nb % 8 == 0) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          chk({tag, "_byte"}, {24'd0, sh}, {24'd0, e});
        end
      end
    end
    nse0 = 0;
    while (i < sym_q.size() && sym_q[i] === 2'b00) begin nse0++; i++; end
    nj = 0;
    while (i < sym_q.size() && sym_q[i] === 2'b10) begin nj++; i++; end
    chk({tag, "_se0"}, nse0, 2);
    chk({tag, "_eopj"}, nj, 1);
    chk({tag, "_trail"}, i, sym_q.size());
    chk({tag, "_stuff"}, sbad, 0);
    chk({tag, "_whole"}, nb % 8, 0);
    chk({tag, "_left"}, exp_q.size(), 0);
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, {26'd0, d_plus, d_minus, tx_ready, tx_busy, tx_done, tx_err}, 32'b101000);
  endtask

  initial begin
    time t0, t1;
    int  dd, de, nd, ne, bad;

    // reset and idle
    repeat (3) @(negedge clk);
    chk_idle("reset");
    n_rst = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if ({d_plus, d_minus, tx_ready, tx_busy, tx_done, tx_err} !== 6'b101000) bad++;
    end
    chk("idle20", bad, 0);

    // single 0x00
    sym_q.delete();
    send_byte(8'h00, 1'b1, t0);
    repeat (130) @(negedge clk);
    chk("x00_se0_line", {30'd0, d_plus, d_minus}, 32'b00);
    chk("x00_ready_eop", {30'd0, tx_ready, tx_busy}, 32'b01);
    wait_done(t0, dd, de, nd, ne);
    chk("x00_done_t", dd, 152);
    chk("x00_ndone", nd, 1);
    chk("x00_nerr", ne, 0);
    chk_syms("x00", "KJKJKJKKJKJKJKJK00J");
    check_pkt("x00");
    chk_idle("x00_after");

    // single 0xFF: stuffed zero after six ones
    sym_q.delete();
    send_byte(8'hFF, 1'b1, t0);
    wait_done(t0, dd, de, nd, ne);
    chk("xff_done_t", dd, 160);
    chk("xff_ndone", nd, 1);
    chk_syms("xff", "KJKJKJKKKKKKKJJJJ00J");
    check_pkt("xff");

    // three back-to-back bytes
    sym_q.delete();
    send_byte(8'hA5, 1'b0, t0);
    send_byte(8'h3C, 1'b0, t1);
    send_byte(8'h81, 1'b1, t1);
    wait_done(t0, dd, de, nd, ne);
    chk("b2b_done_t", dd, 280);
    chk("b2b_ndone", nd, 1);
    chk("b2b_nerr", ne, 0);
    check_pkt("b2b");

    // underrun after one non-last byte
    sym_q.delete();
    send_byte(8'h12, 1'b0, t0);
    wait_done(t0, dd, de, nd, ne);
    chk("ur_err_t", de, 128);
    chk("ur_nerr", ne, 1);
    chk("ur_done_t", dd, 152);
    chk("ur_ndone", nd, 1);
    check_pkt("ur");
    chk_idle("ur_after");

    // reset in the third data bit, then a clean packet
    sym_q.delete();
    send_byte(8'h55, 1'b1, t0);
    repeat (83) @(negedge clk);
    n_rst = 1'b0;
    #1 chk_idle("midrst");
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    sym_q.delete();
    exp_q.delete();
    send_byte(8'hC3, 1'b1, t0);
    wait_done(t0, dd, de, nd, ne);
    chk("post_done_t", dd, 152);
    chk("post_ndone", nd, 1);
    check_pkt("post");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
